// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Latency : one cycle from the ID inputs to the EX outputs; the forwarding muxes sit after the register.
// Backpres: hold freezes the stage and raises stall_id. A load-use hazard inserts one bubble and raises stall_id.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   id_*                        decoded instruction from the ID stage (operands, indices, immediate, control)
//   hold, flush                 downstream freeze request / kill the instruction entering EX
//   exmem_*, memwb_*            forwarding sources (write-enable, destination index, value)
//   operand1/2, alu_ctrl        ALU inputs
//   ex_valid/_reg_write/_mem_*  registered control for EX
//   ex_rd, ex_store_data        registered destination index, forwarded rt value for stores
//   stall_id                    freeze PC and IF/ID
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             hold,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_res,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_data,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic [3:0]       alu_ctrl,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [RA_W-1:0]  ex_rd,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             stall_id
);

  // Pipeline register contents
  logic [WIDTH-1:0] rs_val, rt_val, imm_q;
  logic [RA_W-1:0]  rs_q, rt_q, rd_q;
  logic [3:0]       alu_ctrl_q;
  logic             alu_src_q, reg_write_q, mem_read_q, mem_write_q, valid_q;

  logic [WIDTH-1:0] fwd_rs, fwd_rt;
  logic             load_use;
  logic             bubble;

  // Forwarding: EX/MEM has priority over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_rs = rs_val;
    if (exmem_reg_write && (exmem_rd == rs_q) && (rs_q != '0))
      fwd_rs = exmem_res;
    else if (memwb_reg_write && (memwb_rd == rs_q) && (rs_q != '0))
      fwd_rs = memwb_data;
  end

  always_comb begin
    fwd_rt = rt_val;
    if (exmem_reg_write && (exmem_rd == rt_q) && (rt_q != '0))
      fwd_rt = exmem_res;
    else if (memwb_reg_write && (memwb_rd == rt_q) && (rt_q != '0))
      fwd_rt = memwb_data;
  end

  // A load in EX whose result the instruction in ID needs cannot be forwarded in time.
  assign load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                    ((rd_q == id_rs) || (rd_q == id_rt));

  assign stall_id = hold || load_use;

  // Reset and flush override hold; a load-use bubble only applies when not frozen.
  assign bubble = reset || flush || (!hold && load_use);

  always_ff @(posedge clk) begin
    if (bubble) begin
      rs_val      <= '0;
      rt_val      <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      alu_ctrl_q  <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (hold) begin
      // Latch the forwarded values so they survive their source retiring during the freeze.
      rs_val <= fwd_rs;
      rt_val <= fwd_rt;
    end else begin
      rs_val      <= id_rs_data;
      rt_val      <= id_rt_data;
      imm_q       <= id_imm;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rd_q        <= id_rd;
      alu_ctrl_q  <= id_alu_ctrl;
      alu_src_q   <= id_valid && id_alu_src;
      reg_write_q <= id_valid && id_reg_write;
      mem_read_q  <= id_valid && id_mem_read;
      mem_write_q <= id_valid && id_mem_write;
      valid_q     <= id_valid;
    end
  end

  assign operand1      = fwd_rs;
  assign operand2      = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        hold, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_data;
  logic [31:0] operand1, operand2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_id;
  logic [4:0]  ex_rd;

  id_ex_stage #(.WIDTH(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .hold(hold), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .operand1(operand1), .operand2(operand2), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently occupying EX.
  typedef struct packed {
    logic        vld, rw, mr, mw, asrc, chk2;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv, imm;
    logic [3:0]  ctrl;
  } slot_t;

  typedef struct packed {
    logic [31:0] op1, op2, sd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        vld, rw, mr, mw, stall, chk2;
  } exp_t;

  slot_t s = '0;
  exp_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    arm = 1'b0;

  // Value the ALU should see for register idx whose captured value is own.
  function automatic logic [31:0] fwd_m(input logic [4:0] idx, input logic [31:0] own);
    if (idx != 5'd0 && exmem_reg_write && exmem_rd == idx) return exmem_res;
    if (idx != 5'd0 && memwb_reg_write && memwb_rd == idx) return memwb_data;
    return own;
  endfunction

  // Predict this cycle's outputs from the currently driven inputs, then advance one clock.
  task automatic cycle();
    exp_t  e;
    slot_t ns;
    logic  lu;
    lu = s.vld && s.mr && (s.rd != 5'd0) && id_valid && (s.rd == id_rs || s.rd == id_rt);
    e.op1   = fwd_m(s.rs, s.rsv);
    e.sd    = fwd_m(s.rt, s.rtv);
    e.op2   = s.asrc ? s.imm : e.sd;
    e.ctrl  = s.ctrl;
    e.rd    = s.rd;
    e.vld   = s.vld;
    e.rw    = s.rw;
    e.mr    = s.mr;
    e.mw    = s.mw;
    e.stall = hold || lu;
    e.chk2  = s.chk2;
    if (arm) q.push_back(e);

    if (reset || flush || (!hold && lu)) begin
      ns = '0;
      ns.chk2 = 1'b1;
    end else if (hold) begin
      ns = s;
      ns.rsv = fwd_m(s.rs, s.rsv);
      ns.rtv = fwd_m(s.rt, s.rtv);
    end else begin
      ns.vld  = id_valid;
      ns.rw   = id_valid && id_reg_write;
      ns.mr   = id_valid && id_mem_read;
      ns.mw   = id_valid && id_mem_write;
      ns.asrc = id_alu_src;
      ns.chk2 = id_valid;   // operand2 of a non-instruction is don't-care
      ns.rs   = id_rs;
      ns.rt   = id_rt;
      ns.rd   = id_rd;
      ns.rsv  = id_rs_data;
      ns.rtv  = id_rt_data;
      ns.imm  = id_imm;
      ns.ctrl = id_alu_ctrl;
    end
    @(posedge clk);
    s = ns;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents one EX state; compare it against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("operand1", operand1, e.op1);
        if (e.chk2) chk("operand2", operand2, e.op2);
        chk("store_data", ex_store_data, e.sd);
        chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.vld});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
        chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, e.mw});
        chk("stall_id", {31'd0, stall_id}, {31'd0, e.stall});
      end
    end
  end

  task automatic clr_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_res = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] rsv,
                        input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [3:0] ctrl, input logic asrc,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rs_data = rsv; id_rt = rt; id_rt_data = rtv;
    id_rd = rd; id_imm = imm; id_alu_ctrl = ctrl; id_alu_src = asrc;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic idle_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; hold = 0; flush = 0;
    idle_id(); clr_fwd();
    @(posedge clk); #1;       // DUT state now defined
    arm = 1;
    cycle();                  // reset still high: next state is all-zero
    reset = 0;
    cycle();                  // reset values observed here

    // Basic capture: ADD rs=1 (0x10), rt=2 (0x20)
    set_id(1, 5'd1, 32'h10, 5'd2, 32'h20, 5'd3, 32'h0, 4'b0010, 0, 1, 0, 0);
    cycle();
    // Immediate operand
    set_id(1, 5'd1, 32'h10, 5'd2, 32'h20, 5'd3, 32'hFFFF_FFFC, 4'b0010, 1, 1, 0, 0);
    cycle();
    // rs=0 must not pick up a source claiming rd=0
    set_id(1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 32'h0, 4'b0001, 0, 1, 0, 0);
    cycle();
    exmem_reg_write = 1; exmem_rd = 0; exmem_res = 32'hDEAD_BEEF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'hCAFE_F00D;
    // Dual forward: two consecutive instructions reading r3
    set_id(1, 5'd3, 32'h33, 5'd3, 32'h33, 5'd5, 32'h0, 4'b0011, 0, 1, 0, 0);
    cycle();
    exmem_reg_write = 1; exmem_rd = 3; exmem_res = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'hBBBB;
    cycle();                  // EX rs=3, both sources match: 0xAAAA
    exmem_reg_write = 0;
    idle_id();
    cycle();                  // EX rs=3, only MEM/WB: 0xBBBB
    clr_fwd();

    // Load-use: lw r5, then an instruction reading r5
    set_id(1, 5'd1, 32'h100, 5'd0, 32'h0, 5'd5, 32'h8, 4'b0010, 1, 1, 1, 0);
    cycle();
    set_id(1, 5'd5, 32'h0, 5'd2, 32'h20, 5'd6, 32'h0, 4'b0010, 0, 1, 0, 0);
    cycle();                  // stall_id=1, bubble loaded
    cycle();                  // bubble in EX, dependent captured
    memwb_reg_write = 1; memwb_rd = 5; memwb_data = 32'h5555_0005;
    idle_id();
    cycle();                  // dependent in EX, operand1 from MEM/WB
    clr_fwd();

    // Hold while the forwarding source retires
    set_id(1, 5'd4, 32'h1, 5'd0, 32'h0, 5'd7, 32'h0, 4'b0010, 0, 1, 0, 0);
    cycle();
    idle_id();
    hold = 1; exmem_reg_write = 1; exmem_rd = 4; exmem_res = 32'h1234;
    cycle();
    exmem_reg_write = 0;
    cycle();
    cycle();
    hold = 0;
    cycle();                  // released; still shows 0x1234

    // Flush beats hold with a valid ID instruction
    set_id(1, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h0, 4'b0000, 0, 1, 0, 1);
    hold = 1; flush = 1;
    cycle();
    hold = 0; flush = 0;
    // Flush together with load-use
    set_id(1, 5'd1, 32'h100, 5'd0, 32'h0, 5'd6, 32'h4, 4'b0010, 1, 1, 1, 0);
    cycle();
    set_id(1, 5'd2, 32'h0, 5'd6, 32'h0, 5'd7, 32'h0, 4'b0001, 0, 1, 0, 0);
    flush = 1;
    cycle();
    flush = 0;
    // Reset during a stall
    set_id(1, 5'd1, 32'h100, 5'd0, 32'h0, 5'd7, 32'h4, 4'b0010, 1, 1, 1, 0);
    cycle();
    set_id(1, 5'd7, 32'h0, 5'd7, 32'h0, 5'd8, 32'h0, 4'b0100, 0, 1, 0, 0);
    hold = 1; reset = 1;
    cycle();
    hold = 0; reset = 0;
    idle_id();
    cycle();

    // Randomised traffic, small register indices so forwarding and hazards occur often
    for (int i = 0; i < 3000; i++) begin
      set_id(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
             4'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_res = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_data = $urandom;
      hold  = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end

    reset = 0; hold = 0; flush = 0;
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage directly upstream of the 32-bit ALU.
- Captures decoded operands, immediate, alu_ctrl and control bits from decode, then drives the ALU operand and control inputs.
- Resolves EX/MEM and MEM/WB forwarding and detects load-use hazards.
- Implements stall (hold) and flush (bubble insertion).

Parameters:
- WIDTH, 32, datapath width of operands and results.
- RA_W, 5, register-address width; register 0 is hard-wired zero.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs_data  in  WIDTH  register-file read of rs.
- id_rt_data  in  WIDTH  register-file read of rt.
- id_imm  in  WIDTH  sign/zero-extended immediate.
- id_rs  in  RA_W  rs index.
- id_rt  in  RA_W  rt index.
- id_rd  in  RA_W  destination index, already selected rd or rt.
- id_alu_ctrl  in  4  0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 MUL.
- id_alu_src  in  1  1 selects immediate as operand2.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  decoded control.
- hold  in  1  downstream freeze request.
- flush  in  1  kill the instruction entering EX (branch or jump).
- exmem_reg_write  in  1  EX/MEM forwarding source: write-enable.
- exmem_rd  in  RA_W  EX/MEM forwarding source: destination index.
- exmem_res  in  WIDTH  EX/MEM forwarding source: result.
- memwb_reg_write  in  1  MEM/WB forwarding source: write-enable.
- memwb_rd  in  RA_W  MEM/WB forwarding source: destination index.
- memwb_data  in  WIDTH  MEM/WB forwarding source: data.
- operand1  out  WIDTH  to ALU operand1.
- operand2  out  WIDTH  to ALU operand2.
- alu_ctrl  out  4  to ALU.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control.
- ex_rd  out  RA_W  registered destination index.
- ex_store_data  out  WIDTH  forwarded rt value for stores.
- stall_id  out  1  freeze PC and IF/ID.

Behaviour:
- Internal registers:
  - Data: rs_val, rt_val, imm, rs, rt, rd, alu_ctrl.
  - Control: alu_src, reg_write, mem_read, mem_write, valid.
- Reset: all registers clear to 0, so ex_valid=0, alu_ctrl=0000, ex_rd=0, all control bits 0. Outputs settle to operand1=0, operand2=0, stall_id=0 (absent forwarding matches).
- Forwarding (combinational, post-register), for each source field S in {rs, rt}:
  - If exmem_reg_write and exmem_rd==S and S!=0, use exmem_res.
  - Else if memwb_reg_write and memwb_rd==S and S!=0, use memwb_data.
  - Else use the registered value.
  - EX/MEM always wins over MEM/WB.
- Operand outputs:
  - operand1 = fwd(rs).
  - operand2 = alu_src ? imm : fwd(rt).
  - ex_store_data = fwd(rt).
- Load-use detection (combinational):
  - load_use = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
  - stall_id = hold | load_use.
- Register update priority each clk edge:
  1. reset: clear all.
  2. flush: load bubble (valid, reg_write, mem_read, mem_write = 0; data fields = 0).
  3. hold: retain all fields except rs_val and rt_val, which reload with fwd(rs) and fwd(rt). This keeps forwarded values alive if sources retire during a freeze.
  4. load_use: load bubble; ID is held by stall_id, so the dependent instruction re-enters the next cycle and receives forwarding from MEM/WB.
  5. Otherwise: capture all id_* fields. If id_valid=0, control bits are captured as 0.
- Latency: one cycle, ID to EX outputs.
- Boundaries:
  - flush together with hold: flush wins, bubble inserted.
  - flush together with load_use: bubble, stall_id still asserted that cycle.
  - Reset mid-hold or mid-stall: clears immediately on the next edge.
  - Register 0 is never forwarded, even if a source claims rd=0 with reg_write=1.
  - Bubble control bits must be exactly 0 so downstream never writes.

Test Plan:
- Basic capture: reset, then ID ADD rs=1 (0x10), rt=2 (0x20), alu_src=0 -> next cycle operand1=0x10, operand2=0x20, alu_ctrl=0010, ex_valid=1.
- Immediate and reg-0 rule: alu_src=1, imm=0xFFFFFFFC -> operand2=0xFFFFFFFC. Separately, exmem_rd=0 with reg_write=1 and rs=0 -> operand1 = registered 0, not exmem_res.
- Dual forward: exmem_rd=3 (res 0xAAAA) and memwb_rd=3 (data 0xBBBB), EX rs=3 -> operand1=0xAAAA. With exmem_reg_write=0 -> operand1=0xBBBB.
- Load-use: EX holds lw rd=5, ID instruction has rs=5 -> stall_id=1 for exactly one cycle, next EX is a bubble (ex_valid=0, ex_reg_write=0). The cycle after, the dependent instruction is in EX with operand1=memwb_data.
- Hold with retiring source: EX rs=4, exmem_rd=4 res 0x1234, hold=1 for 3 cycles while exmem_reg_write drops after the first -> operand1 stays 0x1234 throughout, and stall_id=1 for all 3 cycles.
- Flush priority: flush=1 with hold=1 and valid ID -> next cycle ex_valid=0, all control 0. Reset asserted mid-stall -> all outputs return to their reset values on the next edge.
